// File: rtl/player_bullet.sv
// Player bullet: latches fire, launches from the ship on fsync, climbs SPEED px per frame,
// retires on hit or top exit, then reloads. Optional macro RAPID_FIRE_EN removes the cooldown.
module player_bullet #(
    parameter int          BULLET_W        = 4,
    parameter int          BULLET_H        = 8,
    parameter int          SPEED           = 4,
    parameter int          LAUNCH_Y        = 440,
    parameter int          TOP_LIMIT       = 0,
    parameter int          COOLDOWN_FRAMES = 8,
    parameter logic [23:0] COLOR           = 24'hFFFF00
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               fire,
    input  logic signed [11:0] player_x,
    input  logic               alien_hit,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    output logic               bullet_active,
    output logic signed [11:0] bullet_left,
    output logic signed [11:0] bullet_right,
    output logic signed [11:0] bullet_top,
    output logic signed [11:0] bullet_bottom,
    output logic        [7:0]  pixel [0:2],
    output logic               active
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic signed [11:0] HALF_W_C    = 12'(BULLET_W / 2);
    localparam logic signed [11:0] SPEED_C     = 12'(SPEED);
    localparam logic signed [11:0] LAUNCH_Y_C  = 12'(LAUNCH_Y);
    localparam logic signed [11:0] LAUNCH_T_C  = 12'(LAUNCH_Y - BULLET_H);
    localparam logic signed [12:0] TOP_LIM_C   = 13'(TOP_LIMIT);

    state_t             state_r;
    logic               fire_req_r;
`ifndef RAPID_FIRE_EN
    logic        [7:0]  cooldown_r;
`endif
    logic signed [12:0] next_top_s;
    logic               exit_s;
    logic               in_zone_s;

    // Next-frame top in 13 bits so the step past TOP_LIMIT cannot wrap; scan-position hit test.
    always_comb begin
        next_top_s = $signed({bullet_top[11], bullet_top}) - $signed(13'(SPEED));
        exit_s     = (next_top_s < TOP_LIM_C);
        in_zone_s  = bullet_active
                     && (hpos >= bullet_left) && (hpos < bullet_right)
                     && (vpos >= bullet_top)  && (vpos < bullet_bottom);
    end

    // Bullet state machine: launch, per-frame movement, retirement and reload.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            fire_req_r    <= 1'b0;
`ifndef RAPID_FIRE_EN
            cooldown_r    <= 8'd0;
`endif
            bullet_active <= 1'b0;
            bullet_left   <= 12'sd0;
            bullet_right  <= 12'sd0;
            bullet_top    <= 12'sd0;
            bullet_bottom <= 12'sd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fsync && (fire_req_r || fire)) begin
                        bullet_left   <= player_x - HALF_W_C;
                        bullet_right  <= player_x + HALF_W_C;
                        bullet_top    <= LAUNCH_T_C;
                        bullet_bottom <= LAUNCH_Y_C;
                        bullet_active <= 1'b1;
                        fire_req_r    <= 1'b0;
                        state_r       <= FLIGHT;
                    end else if (fire) begin
                        fire_req_r <= 1'b1;
                    end
                end
                FLIGHT: begin
`ifdef RAPID_FIRE_EN
                    if (fire) begin
                        fire_req_r <= 1'b1;
                    end
`endif
                    // A hit takes priority over movement, so edges freeze where the hit happened.
                    if (alien_hit || (fsync && exit_s)) begin
                        bullet_active <= 1'b0;
`ifdef RAPID_FIRE_EN
                        state_r       <= IDLE;
`else
                        cooldown_r    <= 8'(COOLDOWN_FRAMES);
                        if (COOLDOWN_FRAMES == 0) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= COOLDOWN;
                        end
`endif
                    end else if (fsync) begin
                        bullet_top    <= bullet_top - SPEED_C;
                        bullet_bottom <= bullet_bottom - SPEED_C;
                    end
                end
`ifndef RAPID_FIRE_EN
                COOLDOWN: begin
                    if (fsync) begin
                        cooldown_r <= cooldown_r - 8'd1;
                        if (cooldown_r <= 8'd1) begin
                            state_r <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered render output for the compositor.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            pixel[0] <= 8'h00;
            pixel[1] <= 8'h00;
            pixel[2] <= 8'h00;
        end else begin
            active   <= in_zone_s;
            pixel[0] <= in_zone_s ? COLOR[23:16] : 8'h00;
            pixel[1] <= in_zone_s ? COLOR[15:8]  : 8'h00;
            pixel[2] <= in_zone_s ? COLOR[7:0]   : 8'h00;
        end
    end

endmodule

// File: tb/tb_player_bullet.sv
// Directed self-checking bench for player_bullet (default build; RAPID_FIRE_EN section when defined).
module tb_player_bullet;

    logic               pixel_clk = 1'b0;
    logic               rst;
    logic               fsync;
    logic               fire;
    logic               alien_hit;
    logic signed [11:0] player_x;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               bullet_active;
    logic signed [11:0] bullet_left;
    logic signed [11:0] bullet_right;
    logic signed [11:0] bullet_top;
    logic signed [11:0] bullet_bottom;
    logic        [7:0]  pixel [0:2];
    logic               active;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 pixel_clk = ~pixel_clk;

    player_bullet dut (
        .pixel_clk     (pixel_clk),
        .rst           (rst),
        .fsync         (fsync),
        .fire          (fire),
        .player_x      (player_x),
        .alien_hit     (alien_hit),
        .hpos          (hpos),
        .vpos          (vpos),
        .bullet_active (bullet_active),
        .bullet_left   (bullet_left),
        .bullet_right  (bullet_right),
        .bullet_top    (bullet_top),
        .bullet_bottom (bullet_bottom),
        .pixel         (pixel),
        .active        (active)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic pulse_fsync();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        tick();
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
    endtask

    task automatic launch();
        pulse_fire();
        pulse_fsync();
    endtask

    task automatic wait_cooldown();
`ifndef RAPID_FIRE_EN
        repeat (8) pulse_fsync();
`endif
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_bactive"}, 32'(bullet_active), 32'sd0);
        check_val({tag, "_left"},    bullet_left,   32'sd0);
        check_val({tag, "_right"},   bullet_right,  32'sd0);
        check_val({tag, "_top"},     bullet_top,    32'sd0);
        check_val({tag, "_bottom"},  bullet_bottom, 32'sd0);
        check_val({tag, "_active"},  32'(active),   32'sd0);
        check_val({tag, "_r"},       32'(pixel[0]), 32'sd0);
        check_val({tag, "_g"},       32'(pixel[1]), 32'sd0);
        check_val({tag, "_b"},       32'(pixel[2]), 32'sd0);
    endtask

    initial begin
        rst = 1'b1; fsync = 1'b0; fire = 1'b0; alien_hit = 1'b0;
        player_x = 12'sd100; hpos = -12'sd1; vpos = -12'sd1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_zero("reset");

        // Fire alone never launches; the following fsync does.
        pulse_fire();
        tick(); tick();
        check_val("no_launch_wo_fsync", 32'(bullet_active), 32'sd0);
        pulse_fsync();
        check_val("launch_bactive", 32'(bullet_active), 32'sd1);
        check_val("launch_left",    bullet_left,   32'sd98);
        check_val("launch_right",   bullet_right,  32'sd102);
        check_val("launch_top",     bullet_top,    32'sd432);
        check_val("launch_bottom",  bullet_bottom, 32'sd440);

        // Render window, inclusive left/top and exclusive right/bottom.
        hpos = 12'sd98; vpos = 12'sd432; tick();
        check_val("rend_tl_active", 32'(active),   32'sd1);
        check_val("rend_tl_r",      32'(pixel[0]), 32'sd255);
        check_val("rend_tl_g",      32'(pixel[1]), 32'sd255);
        check_val("rend_tl_b",      32'(pixel[2]), 32'sd0);
        hpos = 12'sd102; tick();
        check_val("rend_right_edge", 32'(active), 32'sd0);
        check_val("rend_right_r",    32'(pixel[0]), 32'sd0);
        hpos = 12'sd101; vpos = 12'sd439; tick();
        check_val("rend_br_inside", 32'(active), 32'sd1);
        vpos = 12'sd440; tick();
        check_val("rend_bottom_edge", 32'(active), 32'sd0);
        hpos = -12'sd1; vpos = -12'sd1;

        pulse_fsync();
        check_val("move1_top",    bullet_top,    32'sd428);
        check_val("move1_bottom", bullet_bottom, 32'sd436);
        player_x = 12'sd200;
        pulse_fsync();
        check_val("frozen_left",  bullet_left,  32'sd98);
        check_val("frozen_right", bullet_right, 32'sd102);
        check_val("move2_top",    bullet_top,   32'sd424);

        // 108th move lands exactly on TOP_LIMIT; the 109th fsync retires.
        repeat (106) pulse_fsync();
        check_val("top_at_limit", bullet_top,             32'sd0);
        check_val("alive_at_lim", 32'(bullet_active),     32'sd1);
        pulse_fsync();
        check_val("exit_bactive", 32'(bullet_active), 32'sd0);
        check_val("exit_top",     bullet_top,         32'sd0);
        check_val("exit_bottom",  bullet_bottom,      32'sd8);

`ifndef RAPID_FIRE_EN
        for (int i = 0; i < 8; i++) begin
            pulse_fire();
            pulse_fsync();
            check_val($sformatf("cooldown_%0d", i), 32'(bullet_active), 32'sd0);
        end
        pulse_fsync();
        check_val("no_queued_fire", 32'(bullet_active), 32'sd0);
`endif
        launch();
        check_val("relaunch_bactive", 32'(bullet_active), 32'sd1);
        check_val("relaunch_left",    bullet_left,        32'sd198);
        check_val("relaunch_top",     bullet_top,         32'sd432);

        repeat (33) pulse_fsync();
        check_val("pre_hit_top", bullet_top, 32'sd300);
        alien_hit = 1'b1; tick(); alien_hit = 1'b0;
        check_val("hit_bactive", 32'(bullet_active), 32'sd0);
        check_val("hit_top",     bullet_top,         32'sd300);
        check_val("hit_bottom",  bullet_bottom,      32'sd308);
        check_val("hit_left",    bullet_left,        32'sd198);

        wait_cooldown();
        launch();
        repeat (33) pulse_fsync();
        alien_hit = 1'b1; fsync = 1'b1; tick();
        alien_hit = 1'b0; fsync = 1'b0; tick();
        check_val("hitfs_bactive", 32'(bullet_active), 32'sd0);
        check_val("hitfs_top",     bullet_top,         32'sd300);

        // Asynchronous reset in the middle of a cycle while in flight.
        wait_cooldown();
        launch();
        pulse_fsync();
        check_val("pre_rst_top", bullet_top, 32'sd428);
        hpos = 12'sd199; vpos = 12'sd430; tick();
        check_val("pre_rst_active", 32'(active), 32'sd1);
        @(posedge pixel_clk); #4;
        rst = 1'b1; #1;
        check_zero("midrst");
        tick();
        rst = 1'b0;
        hpos = -12'sd1; vpos = -12'sd1;
        tick();

`ifdef RAPID_FIRE_EN
        fire = 1'b1;
        pulse_fsync();
        check_val("rapid_launch", 32'(bullet_active), 32'sd1);
        alien_hit = 1'b1; tick(); alien_hit = 1'b0;
        check_val("rapid_hit", 32'(bullet_active), 32'sd0);
        pulse_fsync();
        check_val("rapid_relaunch",     32'(bullet_active), 32'sd1);
        check_val("rapid_relaunch_top", bullet_top,         32'sd432);
        fire = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
